// File: rtl/arbitro_mem_dados.sv
// Arbiter sharing one data memory between a CPU (requester 0) and an I/O port (requester 1).
// Optional macro ARB_ROUND_ROBIN_EN switches tie resolution from fixed priority to round-robin.
module arbitro_mem_dados #(
   parameter int LARG_END  = 32,
   parameter int LARG_DADO = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 req0,
   input  logic                 req1,
   input  logic                 escrita0,
   input  logic                 escrita1,
   input  logic [LARG_END-1:0]  endereco0,
   input  logic [LARG_END-1:0]  endereco1,
   input  logic [LARG_DADO-1:0] dado_escrita0,
   input  logic [LARG_DADO-1:0] dado_escrita1,
   output logic                 ack0,
   output logic                 ack1,
   output logic [LARG_DADO-1:0] dado_leitura0,
   output logic [LARG_DADO-1:0] dado_leitura1,
   output logic                 ocupado,
   output logic                 MemRead,
   output logic                 MemWrite,
   output logic [LARG_END-1:0]  mem_endereco,
   output logic [LARG_DADO-1:0] mem_dado_escrita,
   input  logic [LARG_DADO-1:0] mem_dado_leitura
);

   localparam logic [1:0] OCIOSO   = 2'd0;
   localparam logic [1:0] ACESSO   = 2'd1;
   localparam logic [1:0] RESPOSTA = 2'd2;

   logic [1:0]           state_reg;
   logic                 grant_reg;
   logic                 escrita_reg;
   logic                 ack0_reg;
   logic                 ack1_reg;
   logic                 mem_read_reg;
   logic                 mem_write_reg;
   logic [LARG_END-1:0]  mem_endereco_reg;
   logic [LARG_DADO-1:0] mem_dado_escrita_reg;

   logic                 grant_next;
   logic                 escrita_sel;
   logic [LARG_END-1:0]  endereco_sel;
   logic [LARG_DADO-1:0] dado_sel;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_reg;

   // On a tie the requester that was not served last wins.
   always_comb begin
      grant_next = ~req0;
      if (req0 && req1)
         grant_next = ~last_reg;
   end

   always_ff @(posedge clock) begin
      if (reset)
         last_reg <= 1'b1;
      else if (state_reg == OCIOSO && (req0 || req1))
         last_reg <= grant_next;
   end
`else
   always_comb begin
      grant_next = ~req0;
   end
`endif

   always_comb begin
      escrita_sel  = grant_next ? escrita1      : escrita0;
      endereco_sel = grant_next ? endereco1     : endereco0;
      dado_sel     = grant_next ? dado_escrita1 : dado_escrita0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg            <= OCIOSO;
         grant_reg            <= 1'b0;
         escrita_reg          <= 1'b0;
         ack0_reg             <= 1'b0;
         ack1_reg             <= 1'b0;
         mem_read_reg         <= 1'b0;
         mem_write_reg        <= 1'b0;
         mem_endereco_reg     <= '0;
         mem_dado_escrita_reg <= '0;
      end else begin
         case (state_reg)
            OCIOSO: begin
               if (req0 || req1) begin
                  grant_reg            <= grant_next;
                  escrita_reg          <= escrita_sel;
                  mem_endereco_reg     <= endereco_sel;
                  mem_dado_escrita_reg <= dado_sel;
                  mem_read_reg         <= ~escrita_sel;
                  mem_write_reg        <= escrita_sel;
                  state_reg            <= ACESSO;
               end
            end
            ACESSO: begin
               mem_read_reg  <= 1'b0;
               mem_write_reg <= 1'b0;
               ack0_reg      <= ~grant_reg;
               ack1_reg      <= grant_reg;
               state_reg     <= RESPOSTA;
            end
            RESPOSTA: begin
               ack0_reg  <= 1'b0;
               ack1_reg  <= 1'b0;
               state_reg <= OCIOSO;
            end
            default: begin
               mem_read_reg  <= 1'b0;
               mem_write_reg <= 1'b0;
               ack0_reg      <= 1'b0;
               ack1_reg      <= 1'b0;
               state_reg     <= OCIOSO;
            end
         endcase
      end
   end

   // Memory read data arrives during RESPOSTA; write acknowledgements carry zero data.
   assign dado_leitura0    = (ack0_reg && !escrita_reg) ? mem_dado_leitura : '0;
   assign dado_leitura1    = (ack1_reg && !escrita_reg) ? mem_dado_leitura : '0;
   assign ack0             = ack0_reg;
   assign ack1             = ack1_reg;
   assign ocupado          = (state_reg != OCIOSO);
   assign MemRead          = mem_read_reg;
   assign MemWrite         = mem_write_reg;
   assign mem_endereco     = mem_endereco_reg;
   assign mem_dado_escrita = mem_dado_escrita_reg;

endmodule

// File: tb/tb_arbitro_mem_dados.sv
// Self-checking bench for arbitro_mem_dados: directed scenarios plus randomized accesses
// compared against a transaction-level model (expected winner, latency and memory contents).
module tb_arbitro_mem_dados;

   logic        clock = 1'b0;
   logic        reset;
   logic        req0, req1, escrita0, escrita1;
   logic [31:0] endereco0, endereco1, dado_escrita0, dado_escrita1;
   logic        ack0, ack1, ocupado, MemRead, MemWrite;
   logic [31:0] dado_leitura0, dado_leitura1, mem_endereco, mem_dado_escrita, mem_dado_leitura;

   logic [31:0] mem_env [256];
   logic [31:0] ref_mem [256];
   int          last_served;
   int          total = 0;
   int          bad = 0;

   always #5 clock = ~clock;

   arbitro_mem_dados dut (
      .clock(clock), .reset(reset),
      .req0(req0), .req1(req1), .escrita0(escrita0), .escrita1(escrita1),
      .endereco0(endereco0), .endereco1(endereco1),
      .dado_escrita0(dado_escrita0), .dado_escrita1(dado_escrita1),
      .ack0(ack0), .ack1(ack1), .dado_leitura0(dado_leitura0), .dado_leitura1(dado_leitura1),
      .ocupado(ocupado), .MemRead(MemRead), .MemWrite(MemWrite),
      .mem_endereco(mem_endereco), .mem_dado_escrita(mem_dado_escrita),
      .mem_dado_leitura(mem_dado_leitura)
   );

   // Memory attached to the arbiter: read data valid the cycle after MemRead.
   always @(posedge clock) begin
      if (MemWrite) mem_env[mem_endereco[7:0]] <= mem_dado_escrita;
      if (MemRead) mem_dado_leitura <= mem_env[mem_endereco[7:0]];
   end

   task automatic do_reset();
      reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
      @(posedge clock); @(posedge clock); #1;
      reset = 1'b0;
      last_served = 1;
   endtask

   // One arbitration round; caller sits 1 time unit after a rising edge with the DUT idle.
   task automatic serve(input logic r0, input logic r1, input logic w0, input logic w1,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1, input string tag);
      int          who;
      logic        w;
      logic [31:0] a, d, exp_rd, got_rd, other_rd;
      if (r0 && r1) begin
`ifdef ARB_ROUND_ROBIN_EN
         who = (last_served == 1) ? 0 : 1;
`else
         who = 0;
`endif
      end else begin
         who = r0 ? 0 : 1;
      end
      w = (who == 1) ? w1 : w0;
      a = (who == 1) ? a1 : a0;
      d = (who == 1) ? d1 : d0;
      req0 = r0; req1 = r1; escrita0 = w0; escrita1 = w1;
      endereco0 = a0; endereco1 = a1; dado_escrita0 = d0; dado_escrita1 = d1;
      @(posedge clock); @(negedge clock);
      total++;
      if (MemRead !== !w || MemWrite !== w) begin
         bad++; $display("FAIL %s strobes: got rd=%b wr=%b want rd=%b wr=%b", tag, MemRead, MemWrite, !w, w);
      end
      total++;
      if (mem_endereco !== a) begin
         bad++; $display("FAIL %s mem_endereco: got %h want %h", tag, mem_endereco, a);
      end
      if (w) begin
         total++;
         if (mem_dado_escrita !== d) begin
            bad++; $display("FAIL %s mem_dado_escrita: got %h want %h", tag, mem_dado_escrita, d);
         end
      end
      total++;
      if (ocupado !== 1'b1 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
         bad++; $display("FAIL %s access_phase: got ocupado=%b ack0=%b ack1=%b want 1 0 0", tag, ocupado, ack0, ack1);
      end
      @(negedge clock);
      exp_rd = w ? 32'h0 : ref_mem[a[7:0]];
      if (w) ref_mem[a[7:0]] = d;
      got_rd   = (who == 0) ? dado_leitura0 : dado_leitura1;
      other_rd = (who == 0) ? dado_leitura1 : dado_leitura0;
      total++;
      if (ack0 !== 1'(who == 0) || ack1 !== 1'(who == 1)) begin
         bad++; $display("FAIL %s ack: got ack0=%b ack1=%b want winner %0d", tag, ack0, ack1, who);
      end
      total++;
      if (got_rd !== exp_rd) begin
         bad++; $display("FAIL %s dado_leitura: got %h want %h", tag, got_rd, exp_rd);
      end
      total++;
      if (other_rd !== 32'h0 || MemRead !== 1'b0 || MemWrite !== 1'b0) begin
         bad++; $display("FAIL %s response_phase: got other_data=%h rd=%b wr=%b want 0 0 0", tag, other_rd, MemRead, MemWrite);
      end
      $display("%s: req=%b%b winner=%0d %s addr=%h data=%h", tag, r1, r0, who, w ? "write" : "read", a, w ? d : got_rd);
      last_served = who;
      @(posedge clock); #1;
      req0 = 1'b0; req1 = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         total++;
         if (ocupado !== 1'b0 || MemRead !== 1'b0 || MemWrite !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0
             || mem_endereco !== 32'h0 || mem_dado_escrita !== 32'h0) begin
            bad++; $display("FAIL reset_idle: got ocupado=%b rd=%b wr=%b ack=%b%b addr=%h wdata=%h want all 0",
                            ocupado, MemRead, MemWrite, ack1, ack0, mem_endereco, mem_dado_escrita);
         end
      end
      $display("reset: 10 idle cycles checked");
      @(posedge clock); #1;
   endtask

   task automatic test_read();
      serve(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0, "read_cafe");
   endtask

   task automatic test_write_read();
      serve(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h20, 32'h0, 32'h12345678, "write_io");
      serve(1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 32'h0, "read_back");
   endtask

   task automatic test_tie();
      int          winner;
      logic        exp0, exp1;
      logic [31:0] exp_rd;
      do_reset();
      req0 = 1'b1; req1 = 1'b1; escrita0 = 1'b0; escrita1 = 1'b0;
      endereco0 = 32'h31; endereco1 = 32'h42;
      winner = 0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clock);
`ifdef ARB_ROUND_ROBIN_EN
         winner = ((n - 2) / 3) % 2;
`else
         winner = 0;
`endif
         exp0 = (n % 3 == 2) && (winner == 0);
         exp1 = (n % 3 == 2) && (winner == 1);
         total++;
         if (ack0 !== exp0 || ack1 !== exp1) begin
            bad++; $display("FAIL tie_ack cycle %0d: got ack0=%b ack1=%b want %b %b", n, ack0, ack1, exp0, exp1);
         end
         if (n % 3 == 2) begin
            exp_rd = (winner == 0) ? ref_mem[8'h31] : ref_mem[8'h42];
            total++;
            if (((winner == 0) ? dado_leitura0 : dado_leitura1) !== exp_rd) begin
               bad++; $display("FAIL tie_data cycle %0d: got %h want %h", n, (winner == 0) ? dado_leitura0 : dado_leitura1, exp_rd);
            end
            $display("tie: cycle %0d ack to requester %0d", n, winner);
         end
      end
      last_served = winner;
      @(posedge clock); #1;
      req0 = 1'b0; req1 = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      req1 = 1'b1; escrita1 = 1'b0; endereco1 = 32'h55;
      @(posedge clock); @(negedge clock);
      reset = 1'b1; req0 = 1'b1; escrita0 = 1'b0; endereco0 = 32'h66;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         total++;
         if (ack0 !== 1'b0 || ack1 !== 1'b0 || MemRead !== 1'b0 || MemWrite !== 1'b0 || ocupado !== 1'b0) begin
            bad++; $display("FAIL reset_abort: got ack=%b%b rd=%b wr=%b ocupado=%b want all 0",
                            ack1, ack0, MemRead, MemWrite, ocupado);
         end
      end
      $display("reset_mid: access of requester 1 aborted");
      @(posedge clock); #1;
      reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
      last_served = 1;
      serve(1'b1, 1'b1, 1'b0, 1'b0, 32'h66, 32'h55, 32'h0, 32'h0, "tie_after_reset");
   endtask

   task automatic test_random();
      int          pick;
      logic        w0, w1;
      logic [31:0] a0, a1, d0, d1;
      for (int k = 0; k < 40; k++) begin
         pick = $urandom_range(1, 3);
         w0 = 1'($urandom_range(0, 1));
         w1 = 1'($urandom_range(0, 1));
         a0 = 32'($urandom_range(0, 255));
         a1 = 32'($urandom_range(0, 255));
         d0 = $urandom; d1 = $urandom;
         serve(pick[0], pick[1], w0, w1, a0, a1, d0, d1, "random");
      end
   endtask

   initial begin
      reset = 1'b1; req0 = 1'b0; req1 = 1'b0; escrita0 = 1'b0; escrita1 = 1'b0;
      endereco0 = '0; endereco1 = '0; dado_escrita0 = '0; dado_escrita1 = '0;
      for (int i = 0; i < 256; i++) begin
         mem_env[i] = $urandom;
         ref_mem[i] = mem_env[i];
      end
      mem_env[8'h10] = 32'hCAFE0001;
      ref_mem[8'h10] = 32'hCAFE0001;
      last_served = 1;
      @(posedge clock); #1;
      test_reset();
      test_read();
      test_write_read();
      test_tie();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
